mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Sequences every RAM access requested by the microprogrammed control unit.
- Latches the request when the MemEn microfield rises, then drives RAM address, byte enables and write data, and waits for the RAM acknowledge.
- Returns MOC (memory operation complete) to the microsequencer condition mux, plus aligned and extended read data for the MDR.
- Sits between the control unit / MAR / MDR and the synchronous RAM model.

Parameters:
- ADDR_W, 9, byte-address width of MAR/RAM
- TIMEOUT, 15, max cycles spent in WAIT before an access is aborted (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_en  in  1  access request from microstore (level; held until moc seen)
- rw  in  1  1 = read, 0 = write
- data_type  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- sign_ext  in  1  read only: 1 = sign-extend byte/halfword, 0 = zero-extend
- addr  in  ADDR_W  byte address from MAR
- wdata  in  32  store data from MDR (right-justified)
- ram_en  out  1  RAM strobe
- ram_rw  out  1  copy of latched rw
- ram_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0)
- ram_be  out  4  byte-lane enables, lane k = bits [8k+7:8k]
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM read word, valid with ram_ack
- ram_ack  in  1  RAM completion, single-cycle
- rdata  out  32  extracted/extended load data to MDR mux
- moc  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with moc
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; ram_en, ram_rw, ram_addr, ram_be, ram_wdata, rdata, moc, err, busy all 0; timeout counter 0. Reset asserted mid-access drops ram_en immediately and discards the access.
- FSM states: IDLE, ISSUE, WAIT, DONE, HOLD.
- IDLE: at a clock edge with mem_en=1, latch rw, data_type, sign_ext, addr and wdata.
  - Reserved type, or misalignment (halfword addr[0]=1; word addr[1:0]!=0) -> DONE with err set.
  - Otherwise -> ISSUE.
- ISSUE: ram_en=1 with address, be and data driven from latched values. ram_ack=1 -> DONE; else -> WAIT. Counter cleared.
- WAIT: ram_en held. ram_ack=1 -> DONE. Counter increments each cycle; counter reaching TIMEOUT without ack -> DONE with err. ram_ack in the same cycle the counter hits TIMEOUT counts as success.
- DONE: moc=1 for exactly this cycle; err=1 if flagged; ram_en=0. Next state is HOLD if mem_en=1, else IDLE.
- HOLD: wait for mem_en=0, then IDLE. No new request can start until mem_en has dropped, so a held MemEn never triggers a second access.
- Latency: with ack in ISSUE, moc is high 2 cycles after the edge that sampled mem_en.
- Byte enables:
  - byte: 1<<addr[1:0]
  - halfword: 0011 or 1100 by addr[1]
  - word: 1111
  - error: 0000, no RAM strobe
- Write data: byte replicated into all 4 lanes; halfword into both halves; word unchanged.
- Read data: on ack, selected lane shifted to bit 0 and extended per sign_ext to 32 bits. rdata is held until the next successful read. Writes and errors leave rdata unchanged.
- Inputs other than mem_en are ignored outside IDLE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: misaligned halfword/word accesses raise err as above, and no RAM access occurs.
- Undefined: no alignment error. The offending low address bits are ignored (halfword uses addr[1], word uses lane 0) and the access proceeds normally. Reserved data_type still errors.

Test Plan:
- Reset mid-WAIT: rst_n low while ram_en=1 -> ram_en, busy, moc drop to 0 asynchronously, state IDLE.
- Word read at addr 0x004, ram_rdata=0xDEADBEEF, ack in ISSUE -> ram_be=1111, ram_addr=0x004, moc pulse 2 cycles after request, rdata=0xDEADBEEF, err=0.
- Byte read at addr 0x007, sign_ext=1, ram_rdata=0x80112233 -> ram_be=1000, rdata=0xFFFFFF80; repeat with sign_ext=0 -> rdata=0x00000080.
- Halfword write at addr 0x00A, wdata=0x0000ABCD, ack after 3 WAIT cycles -> ram_be=1100, ram_wdata=0xABCDABCD, ram_rw=0, moc 1 cycle after ack, rdata unchanged.
- No ack, TIMEOUT=15 -> ram_en drops after 15 WAIT cycles, moc=err=1 for one cycle; mem_en held high keeps FSM in HOLD with no re-issue until mem_en=0.
- Word read at addr 0x002 with MEM_ALIGN_CHECK_EN -> no ram_en, moc=err=1 one cycle after request; without macro -> ram_addr=0x000, be=1111, normal completion.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// RAM-side bus between the memory access controller and the synchronous RAM.
//
// Handshake: ram_en is a level request. Address, byte enables, write data and
// ram_rw are valid and stable for every cycle ram_en is high. The RAM answers
// with a single-cycle ram_ack (ram_rdata valid in that same cycle). The request
// completes at the clock edge that samples ram_ack=1, and ram_en drops after
// that edge. ram_en may also drop without an ack when the access is abandoned.
//
// Signals:
//   ram_en     controller -> RAM  access strobe
//   ram_rw     controller -> RAM  1 = read, 0 = write
//   ram_addr   controller -> RAM  word-aligned byte address
//   ram_be     controller -> RAM  byte-lane enables (lane k = bits [8k+7:8k])
//   ram_wdata  controller -> RAM  lane-replicated store data
//   ram_rdata  RAM -> controller  read word, valid with ram_ack
//   ram_ack    RAM -> controller  single-cycle completion
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              ram_en;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ack;

  modport master (
    output ram_en, ram_rw, ram_addr, ram_be, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_en, ram_rw, ram_addr, ram_be, ram_wdata,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Sequences RAM accesses requested by the microprogrammed control unit.
// A request is latched when mem_en is seen in IDLE; the controller then
// strobes the RAM until it acknowledges (or the wait times out), pulses moc
// (with err on failure) and waits for mem_en to drop before accepting the
// next request, so a held MemEn never triggers a second access.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   mem_en          access request level from the microstore
//   rw              1 = read, 0 = write
//   data_type       00 byte, 01 halfword, 10 word, 11 reserved
//   sign_ext        loads: 1 = sign-extend, 0 = zero-extend
//   addr            byte address from MAR
//   wdata           right-justified store data from MDR
//   ram             RAM bus (mem_access_ctrl_if.master)
//   rdata           aligned/extended load data, held until the next good read
//   moc             one-cycle memory-operation-complete pulse
//   err             one-cycle error pulse, coincident with moc
//   busy            high whenever the FSM is not in IDLE
//   state_dbg       current FSM state encoding
//
// Build option: MEM_ALIGN_CHECK_EN
//   defined   - misaligned halfword/word requests fail with err, no RAM access
//   undefined - low address bits are ignored and the access proceeds
// Reserved data_type always fails.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              rw,
  input  logic [1:0]        data_type,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  mem_access_ctrl_if.master ram,
  output logic [31:0]       rdata,
  output logic              moc,
  output logic              err,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t            state, state_nxt;

  logic              lat_rw;
  logic              lat_sext;
  logic              lat_err;
  logic [1:0]        lat_type;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [7:0]        cnt;

  logic              req_err;
  logic              accessing;
  logic              timeout_hit;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       rd_ext;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  // Request error check on the live inputs, evaluated only in IDLE.
  always_comb begin
    req_err = (data_type == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
    if (data_type == 2'b01 && addr[0])          req_err = 1'b1;
    if (data_type == 2'b10 && addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  assign accessing   = (state == S_ISSUE) || (state == S_WAIT);
  // Counter sits at TIMEOUT-1 in the last permitted WAIT cycle; an ack in
  // that same cycle still wins.
  assign timeout_hit = (state == S_WAIT) && !ram.ram_ack && (cnt == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mem_en) state_nxt = req_err ? S_DONE : S_ISSUE;
      S_ISSUE: state_nxt = ram.ram_ack ? S_DONE : S_WAIT;
      S_WAIT:  if (ram.ram_ack || timeout_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = mem_en ? S_HOLD : S_IDLE;
      S_HOLD:  if (!mem_en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane steering for the latched request.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = lat_wdata;
    rd_byte   = ram.ram_rdata[{lat_addr[1:0], 3'b000} +: 8];
    rd_half   = ram.ram_rdata[{lat_addr[1], 4'b0000} +: 16];
    rd_ext    = ram.ram_rdata;
    case (lat_type)
      2'b00: begin
        be        = 4'b0001 << lat_addr[1:0];
        wdata_rep = {4{lat_wdata[7:0]}};
        rd_ext    = {{24{lat_sext & rd_byte[7]}}, rd_byte};
      end
      2'b01: begin
        be        = lat_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{lat_wdata[15:0]}};
        rd_ext    = {{16{lat_sext & rd_half[15]}}, rd_half};
      end
      2'b10: begin
        be        = 4'b1111;
        wdata_rep = lat_wdata;
        rd_ext    = ram.ram_rdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = lat_wdata;
        rd_ext    = ram.ram_rdata;
      end
    endcase
  end

  // Request latch, WAIT counter, error flag and load-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rw    <= 1'b0;
      lat_sext  <= 1'b0;
      lat_err   <= 1'b0;
      lat_type  <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
      cnt       <= 8'h0;
      rdata     <= 32'h0;
    end else begin
      if (state == S_IDLE && mem_en) begin
        lat_rw    <= rw;
        lat_sext  <= sign_ext;
        lat_type  <= data_type;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_err   <= req_err;
      end
      if (state == S_ISSUE)     cnt <= 8'h0;
      else if (state == S_WAIT) cnt <= cnt + 8'h1;
      if (timeout_hit) lat_err <= 1'b1;
      if (accessing && ram.ram_ack && lat_rw) rdata <= rd_ext;
    end
  end

  // Bus outputs are gated so the RAM sees nothing outside an active access.
  assign ram.ram_en    = accessing;
  assign ram.ram_rw    = lat_rw;
  assign ram.ram_addr  = accessing ? {lat_addr[ADDR_W-1:2], 2'b00} : '0;
  assign ram.ram_be    = accessing ? be : 4'b0000;
  assign ram.ram_wdata = accessing ? wdata_rep : 32'h0;

  assign moc       = (state == S_DONE);
  assign err       = (state == S_DONE) && lat_err;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
